speech_frame_buffer: RTL and testbench

SPEECH_FRAME_BUFFER -- requirements
Module: speech_frame_buffer

---
 rtl/speech_frame_buffer.sv | 219 +++++++++++++++++++++
 tb/tb_speech_frame_buffer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/speech_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : speech_frame_buffer
// Description : Circular WIN_LEN x 16 sample window with frame-ready flagging
//               and a valid/ready window readout, oldest sample first.
//               Optional FRAME_CNT_EN adds a 16-bit frame_count output.
// Revision    : 1.0 - initial release
// ============================================================================
module speech_frame_buffer #(
    parameter int FRAME_LEN = 80,
    parameter int WIN_LEN   = 240
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic [15:0] audio_in,
    output logic        frame_ready,
    input  logic        rd_start,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
`ifdef FRAME_CNT_EN
    output logic [15:0] frame_count,
`endif
    output logic        overrun
);

    localparam int c_aw = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int c_cw = $clog2(WIN_LEN + 1);
    localparam int c_fw = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [c_aw-1:0] c_addr_last   = c_aw'(WIN_LEN - 1);
    localparam logic [c_cw-1:0] c_win_cnt     = c_cw'(WIN_LEN);
    localparam logic [c_cw-1:0] c_win_cnt_lst = c_cw'(WIN_LEN - 1);
    localparam logic [c_fw-1:0] c_samp_last   = c_fw'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    logic [15:0] mem [WIN_LEN];

    state_t          state_q,       state_d;
    logic [c_aw-1:0] wp_q,          wp_d;
    logic [c_aw-1:0] clr_addr_q,    clr_addr_d;
    logic [c_fw-1:0] samp_cnt_q,    samp_cnt_d;
    logic            frame_ready_q, frame_ready_d;
    logic [c_aw-1:0] base_q,        base_d;
    logic [c_aw-1:0] rd_addr_q,     rd_addr_d;
    logic [c_cw-1:0] issue_cnt_q,   issue_cnt_d;
    logic [c_cw-1:0] hs_cnt_q,      hs_cnt_d;
    logic            out_valid_q,   out_valid_d;
    logic            out_last_q,    out_last_d;
    logic            overrun_q,     overrun_d;
    logic [15:0]     out_data_q;
`ifdef FRAME_CNT_EN
    logic [15:0]     frame_cnt_q,   frame_cnt_d;
`endif

    logic            w_clearing;
    logic            w_wr;
    logic            w_frame_done;
    logic            w_accept;
    logic            w_hs;
    logic            w_load;
    logic [c_cw-1:0] w_offset;
    logic            w_mem_we;
    logic [c_aw-1:0] w_mem_waddr;
    logic [15:0]     w_mem_wdata;

    assign w_clearing   = (state_q == ST_CLEAR);
    assign w_wr         = ce && !w_clearing;
    assign w_frame_done = w_wr && (samp_cnt_q == c_samp_last);
    assign w_accept     = (state_q == ST_IDLE) && frame_ready_q && rd_start;
    assign w_hs         = out_valid_q && out_ready;
    assign w_load       = (state_q == ST_READ) && (issue_cnt_q != c_win_cnt)
                          && (!out_valid_q || out_ready);

    // Distance of the write slot from the oldest slot of the window being read
    assign w_offset = (wp_q >= base_q) ? (c_cw'(wp_q) - c_cw'(base_q))
                                       : (c_cw'(wp_q) + c_win_cnt - c_cw'(base_q));

    assign w_mem_we    = w_clearing || w_wr;
    assign w_mem_waddr = w_clearing ? clr_addr_q : wp_q;
    assign w_mem_wdata = w_clearing ? 16'h0000 : audio_in;

    always_comb begin
        state_d       = state_q;
        wp_d          = wp_q;
        clr_addr_d    = clr_addr_q;
        samp_cnt_d    = samp_cnt_q;
        frame_ready_d = frame_ready_q;
        base_d        = base_q;
        rd_addr_d     = rd_addr_q;
        issue_cnt_d   = issue_cnt_q;
        hs_cnt_d      = hs_cnt_q;
        out_valid_d   = out_valid_q;
        out_last_d    = out_last_q;
        overrun_d     = overrun_q;
`ifdef FRAME_CNT_EN
        frame_cnt_d   = frame_cnt_q + {15'd0, w_frame_done};
`endif

        if (w_clearing) begin
            clr_addr_d = (clr_addr_q == c_addr_last) ? '0 : clr_addr_q + 1'b1;
            if (clr_addr_q == c_addr_last) begin
                state_d = ST_IDLE;
            end
            if (ce) begin
                overrun_d = 1'b1;
            end
        end

        if (w_wr) begin
            wp_d       = (wp_q == c_addr_last) ? '0 : wp_q + 1'b1;
            samp_cnt_d = w_frame_done ? '0 : samp_cnt_q + 1'b1;
            if ((state_q == ST_READ) && (w_offset >= hs_cnt_q)) begin
                overrun_d = 1'b1;
            end
        end

        if (w_accept) begin
            frame_ready_d = 1'b0;
            state_d       = ST_READ;
            base_d        = wp_q;
            rd_addr_d     = wp_q;
            issue_cnt_d   = '0;
            hs_cnt_d      = '0;
        end

        // A frame completing on the accept cycle belongs to the next readout
        if (w_frame_done) begin
            frame_ready_d = 1'b1;
            if (frame_ready_q && !w_accept) begin
                overrun_d = 1'b1;
            end
        end

        if (state_q == ST_READ) begin
            if (w_hs) begin
                hs_cnt_d = hs_cnt_q + 1'b1;
            end
            if (w_load) begin
                out_valid_d = 1'b1;
                out_last_d  = (issue_cnt_q == c_win_cnt_lst);
                issue_cnt_d = issue_cnt_q + 1'b1;
                rd_addr_d   = (rd_addr_q == c_addr_last) ? '0 : rd_addr_q + 1'b1;
            end else if (w_hs) begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
            if (w_hs && out_last_q) begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_CLEAR;
            wp_q          <= '0;
            clr_addr_q    <= '0;
            samp_cnt_q    <= '0;
            frame_ready_q <= 1'b0;
            base_q        <= '0;
            rd_addr_q     <= '0;
            issue_cnt_q   <= '0;
            hs_cnt_q      <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            overrun_q     <= 1'b0;
            out_data_q    <= 16'h0000;
`ifdef FRAME_CNT_EN
            frame_cnt_q   <= 16'h0000;
`endif
        end else begin
            state_q       <= state_d;
            wp_q          <= wp_d;
            clr_addr_q    <= clr_addr_d;
            samp_cnt_q    <= samp_cnt_d;
            frame_ready_q <= frame_ready_d;
            base_q        <= base_d;
            rd_addr_q     <= rd_addr_d;
            issue_cnt_q   <= issue_cnt_d;
            hs_cnt_q      <= hs_cnt_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            overrun_q     <= overrun_d;
            if (w_load) begin
                out_data_q <= mem[rd_addr_q];
            end
`ifdef FRAME_CNT_EN
            frame_cnt_q   <= frame_cnt_d;
`endif
        end
    end

    assign frame_ready = frame_ready_q;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign overrun     = overrun_q;
`ifdef FRAME_CNT_EN
    assign frame_count = frame_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_speech_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_speech_frame_buffer
// Description : Directed self-checking bench for speech_frame_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_speech_frame_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [15:0] audio_in;
    logic        frame_ready;
    logic        rd_start;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        overrun;
`ifdef FRAME_CNT_EN
    logic [15:0] frame_count;
`endif

    int total = 0;
    int bad   = 0;
    int exp_v;

    always #5 clk = ~clk;

    speech_frame_buffer #(
        .FRAME_LEN (80),
        .WIN_LEN   (240)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .audio_in    (audio_in),
        .frame_ready (frame_ready),
        .rd_start    (rd_start),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
`ifdef FRAME_CNT_EN
        .frame_count (frame_count),
`endif
        .overrun     (overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; rd_start = 1'b0; out_ready = 1'b0; audio_in = 16'h0000;
        tick(); tick();
        chk("rst_frame_ready", 32'(frame_ready), 32'd0);
        chk("rst_out_valid",   32'(out_valid),   32'd0);
        chk("rst_out_last",    32'(out_last),    32'd0);
        chk("rst_out_data",    32'(out_data),    32'd0);
        chk("rst_overrun",     32'(overrun),     32'd0);
        chk("rst_state_clear", 32'(dut.state_q), 32'd0);
`ifdef FRAME_CNT_EN
        chk("rst_frame_count", 32'(frame_count), 32'd0);
`endif

        // ce during the 10th clear cycle is dropped and flagged
        rst = 1'b0;
        repeat (9) tick();
        chk("clr_overrun_pre", 32'(overrun), 32'd0);
        ce = 1'b1; audio_in = 16'h7777;
        tick();
        ce = 1'b0;
        chk("clr_ce_overrun", 32'(overrun), 32'd1);
        repeat (229) tick();
        chk("clr_still_clear", 32'(dut.state_q), 32'd0);
        tick();
        chk("clr_to_idle", 32'(dut.state_q), 32'd1);
        chk("clr_frame_ready", 32'(frame_ready), 32'd0);

        // First frame; rd_start on the 80th write must be ignored
        for (int i = 1; i <= 80; i++) begin
            ce = 1'b1; audio_in = 16'(i); rd_start = (i == 80);
            tick();
            if (i == 79) chk("f1_ready_at79", 32'(frame_ready), 32'd0);
        end
        ce = 1'b0; rd_start = 1'b0;
        chk("f1_ready_at80", 32'(frame_ready), 32'd1);
        chk("f1_rd_ignored", 32'(dut.state_q), 32'd1);

        rd_start = 1'b1;
        tick();
        rd_start = 1'b0; out_ready = 1'b1;
        chk("rd1_state_read", 32'(dut.state_q), 32'd2);
        chk("rd1_ready_clr",  32'(frame_ready), 32'd0);
        chk("rd1_no_early",   32'(out_valid),   32'd0);
        tick();
        for (int i = 0; i < 240; i++) begin
            exp_v = (i < 160) ? 0 : i - 159;
            chk("rd1_valid", 32'(out_valid), 32'd1);
            chk("rd1_data",  32'(out_data),  32'(exp_v));
            chk("rd1_last",  32'(out_last),  32'(i == 239));
            tick();
        end
        chk("rd1_done_valid", 32'(out_valid), 32'd0);
        chk("rd1_done_idle",  32'(dut.state_q), 32'd1);

        // Full window written from wp=80, read back across the address wrap
        for (int i = 1; i <= 240; i++) begin
            ce = 1'b1; audio_in = 16'(i);
            tick();
        end
        ce = 1'b0;
        chk("f3_ready", 32'(frame_ready), 32'd1);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        tick();
        for (int i = 0; i < 240; i++) begin
            chk("rd2_valid", 32'(out_valid), 32'd1);
            chk("rd2_data",  32'(out_data),  32'(i + 1));
            chk("rd2_last",  32'(out_last),  32'(i == 239));
            if (i == 50) begin
                out_ready = 1'b0;
                tick();
                chk("stall1_data",  32'(out_data),  32'd51);
                chk("stall1_valid", 32'(out_valid), 32'd1);
                tick();
                chk("stall2_data",  32'(out_data),  32'd51);
                chk("stall2_last",  32'(out_last),  32'd0);
                out_ready = 1'b1;
            end
            tick();
        end
        chk("rd2_done_valid", 32'(out_valid), 32'd0);

        // Two frames without a readout: second completion is an overrun
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_overrun", 32'(overrun), 32'd0);
        repeat (240) tick();
        chk("rst2_idle", 32'(dut.state_q), 32'd1);
        for (int i = 1; i <= 160; i++) begin
            ce = 1'b1; audio_in = 16'(i);
            tick();
            if (i == 80)  chk("ov_ready80",   32'(frame_ready), 32'd1);
            if (i == 80)  chk("ov_none80",    32'(overrun),     32'd0);
            if (i == 159) chk("ov_none159",   32'(overrun),     32'd0);
        end
        ce = 1'b0;
        chk("ov_set160",   32'(overrun),     32'd1);
        chk("ov_ready160", 32'(frame_ready), 32'd1);
`ifdef FRAME_CNT_EN
        chk("ov_frame_count", 32'(frame_count), 32'd2);
`endif

        // Reset while the 100th sample is on the output
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        tick();
        for (int i = 0; i < 99; i++) begin
            tick();
        end
        chk("rd3_s100_valid", 32'(out_valid), 32'd1);
        chk("rd3_s100_data",  32'(out_data),  32'd20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrd_valid",   32'(out_valid),   32'd0);
        chk("midrd_ready",   32'(frame_ready), 32'd0);
        chk("midrd_clear",   32'(dut.state_q), 32'd0);
        chk("midrd_data",    32'(out_data),    32'd0);
        chk("midrd_overrun", 32'(overrun),     32'd0);

        // Write into an unread slot during readout
        repeat (240) tick();
        for (int i = 1; i <= 80; i++) begin
            ce = 1'b1; audio_in = 16'(i);
            tick();
        end
        ce = 1'b0;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        tick();
        chk("rdwr_pre", 32'(overrun), 32'd0);
        ce = 1'b1; audio_in = 16'h0005;
        tick();
        ce = 1'b0;
        chk("rdwr_overrun", 32'(overrun), 32'd1);
`ifdef FRAME_CNT_EN
        chk("rdwr_frame_count", 32'(frame_count), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
